mem_stage_lsu: RTL and testbench

//   MEM-stage load/store unit of the 5-stage RV32I pipeline. Converts EX/MEM loads and stores

---
 rtl/riscv_pkg.sv | 35 +++
 rtl/load_extend.sv | 30 +++
 rtl/mem_stage_lsu.sv | 156 +++++++++++++++
 tb/tb_mem_stage_lsu.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the MEM-stage load/store unit.
//   - funct3 encodings for loads and stores
//   - lsu_state_t: LSU handshake FSM states
//   - is_byte / is_half / is_misaligned: access-size helpers. Any funct3 that is
//     not a byte or half access is handled as a word access.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

    function automatic logic is_byte(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_BU);
    endfunction

    function automatic logic is_half(input logic [2:0] f3);
        return (f3 == F3_H) || (f3 == F3_HU);
    endfunction

    // Bytes are always aligned, halves need a[0]==0, words need a[1:0]==0.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        if (is_byte(f3)) begin
            return 1'b0;
        end
        if (is_half(f3)) begin
            return a[0];
        end
        return a != 2'b00;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Load data alignment and extension (purely combinational).
//   rdata  : 32-bit word returned by data memory
//   offset : byte offset of the access within the word (address bits [1:0])
//   funct3 : access size/sign
//   result : selected byte/half, sign- or zero-extended; word passes through
module load_extend
    import riscv_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{offset, 3'b000} +: 8];
        half_sel = rdata[{offset[1], 4'b0000} +: 16];
        case (funct3)
            F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   result = {24'h000000, byte_sel};
            F3_H:    result = {{16{half_sel[15]}}, half_sel};
            F3_HU:   result = {16'h0000, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit of the 5-stage RV32I pipeline.
// Turns the EX/MEM load/store into a valid/ready request on the data-memory
// port, stalls the pipeline until it completes, and delivers the aligned and
// extended load result in ReadData_M. Misaligned accesses never reach the bus.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   MemRead_M/MemWrite_M     load/store present in MEM
//   funct3_M                 access size/sign
//   ALUResult_M, WriteData_M byte address and store data
//   Stall_M                  high while the access is pending
//   ReadData_M               registered load result
//   misaligned_M             combinational misalignment flag
//   bus_error_M              load timed out (DONE cycle only)
//   dmem_*                   request channel (valid/ready) and response channel
module mem_stage_lsu
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead_M,
    input  logic        MemWrite_M,
    input  logic [2:0]  funct3_M,
    input  logic [31:0] ALUResult_M,
    input  logic [31:0] WriteData_M,
    output logic        Stall_M,
    output logic [31:0] ReadData_M,
    output logic        misaligned_M,
    output logic        bus_error_M,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_resp_valid,
    input  logic [31:0] dmem_rdata
);

    // Last counter value spent in WAIT: the FSM waits exactly TIMEOUT_CYCLES cycles.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    lsu_state_t  state_reg, state_next;
    logic [7:0]  cnt_reg;
    logic [2:0]  f3_reg;
    logic [1:0]  off_reg;
    logic        mem_op;
    logic        access;
    logic        timeout_hit;
    logic [3:0]  wstrb_c;
    logic [31:0] wdata_c;
    logic [31:0] load_result;

    assign mem_op       = MemRead_M | MemWrite_M;
    assign misaligned_M = mem_op & is_misaligned(funct3_M, ALUResult_M[1:0]);
    assign access       = mem_op & ~misaligned_M;
    assign timeout_hit  = (cnt_reg == CNT_LAST);

    // Store lane formation: data replicated across lanes, strobes pick the lanes.
    always_comb begin
        if (is_byte(funct3_M)) begin
            wstrb_c = 4'b0001 << ALUResult_M[1:0];
            wdata_c = {4{WriteData_M[7:0]}};
        end else if (is_half(funct3_M)) begin
            wstrb_c = 4'b0011 << ALUResult_M[1:0];
            wdata_c = {2{WriteData_M[15:0]}};
        end else begin
            wstrb_c = 4'hF;
            wdata_c = WriteData_M;
        end
    end

    load_extend u_load_extend (
        .rdata  (dmem_rdata),
        .offset (off_reg),
        .funct3 (f3_reg),
        .result (load_result)
    );

    always_comb begin
        state_next = state_reg;
        Stall_M    = 1'b0;
        case (state_reg)
            IDLE: begin
                Stall_M = access;
                if (access) state_next = REQ;
            end
            REQ: begin
                Stall_M = 1'b1;
                if (dmem_req_ready) state_next = dmem_we ? DONE : WAIT;
            end
            WAIT: begin
                Stall_M = 1'b1;
                if (dmem_resp_valid || timeout_hit) state_next = DONE;
            end
            DONE: begin
                // Stall released: the instruction leaves MEM on this edge.
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= 8'd0;
            f3_reg         <= 3'd0;
            off_reg        <= 2'd0;
            ReadData_M     <= 32'd0;
            bus_error_M    <= 1'b0;
            dmem_req_valid <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= 32'd0;
            dmem_wdata     <= 32'd0;
            dmem_wstrb     <= 4'd0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (access) begin
                        // Request fields are frozen here and held through REQ.
                        dmem_req_valid <= 1'b1;
                        dmem_we        <= MemWrite_M;
                        dmem_addr      <= {ALUResult_M[31:2], 2'b00};
                        dmem_wdata     <= wdata_c;
                        dmem_wstrb     <= wstrb_c;
                        f3_reg         <= funct3_M;
                        off_reg        <= ALUResult_M[1:0];
                    end else if (MemRead_M && misaligned_M) begin
                        ReadData_M <= 32'd0;
                    end
                end
                REQ: begin
                    if (dmem_req_ready) dmem_req_valid <= 1'b0;
                end
                WAIT: begin
                    cnt_reg <= cnt_reg + 8'd1;
                    if (dmem_resp_valid) begin
                        ReadData_M <= load_result;
                    end else if (timeout_hit) begin
                        ReadData_M  <= 32'd0;
                        bus_error_M <= 1'b1;
                    end
                end
                DONE: begin
                    cnt_reg     <= 8'd0;
                    bus_error_M <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu. A transaction-level model
// predicts, per cycle of each transaction, the stall, request, error and load
// outputs; a few hand-computed literals pin the model.
module tb_mem_stage_lsu;

    localparam int T = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead_M, MemWrite_M;
    logic [2:0]  funct3_M;
    logic [31:0] ALUResult_M, WriteData_M;
    logic        Stall_M;
    logic [31:0] ReadData_M;
    logic        misaligned_M, bus_error_M;
    logic        dmem_req_valid, dmem_req_ready, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_resp_valid;
    logic [31:0] dmem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage_lsu #(.TIMEOUT_CYCLES(T)) dut (
        .clk             (clk),
        .rst             (rst),
        .MemRead_M       (MemRead_M),
        .MemWrite_M      (MemWrite_M),
        .funct3_M        (funct3_M),
        .ALUResult_M     (ALUResult_M),
        .WriteData_M     (WriteData_M),
        .Stall_M         (Stall_M),
        .ReadData_M      (ReadData_M),
        .misaligned_M    (misaligned_M),
        .bus_error_M     (bus_error_M),
        .dmem_req_valid  (dmem_req_valid),
        .dmem_req_ready  (dmem_req_ready),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_wdata      (dmem_wdata),
        .dmem_wstrb      (dmem_wstrb),
        .dmem_resp_valid (dmem_resp_valid),
        .dmem_rdata      (dmem_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int m_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic m_mis(input logic [2:0] f3, input logic [31:0] a);
        return (a % m_size(f3)) != 0;
    endfunction

    function automatic logic [3:0] m_wstrb(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] r;
        int off = int'(a % 4);
        int sz  = m_size(f3);
        for (int i = 0; i < 4; i++) r[i] = (i >= off) && (i < off + sz);
        return r;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        int sz = m_size(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
        logic [31:0] v, mask;
        int sz = m_size(f3);
        if (sz == 4) return rd;
        v    = rd >> (8 * (a % 4));
        mask = (sz == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
        v    = v & mask;
        if (!f3[2] && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    // One instruction in MEM: k counts cycles from when it is presented.
    // dr = cycles ready is withheld in REQ, ds = cycles resp is withheld in WAIT.
    task automatic run_txn(input string name, input logic rd, input logic wr,
                           input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rdata,
                           input int dr, input int ds, input logic no_resp,
                           output int stall_cnt, output logic [31:0] rd_out,
                           output logic [31:0] wdata_seen, output logic [3:0] wstrb_seen,
                           output logic berr_seen);
        logic mis = m_mis(f3, addr);
        logic acc = !mis;
        logic tmo = rd && acc && no_resp;
        int   done_k;
        logic [31:0] exp_rd;
        if (!acc)      done_k = 0;
        else if (wr)   done_k = 2 + dr;
        else if (tmo)  done_k = 2 + dr + T;
        else           done_k = 3 + dr + ds;
        exp_rd = (mis || tmo) ? 32'd0 : m_load(f3, addr, rdata);
        stall_cnt = 0; rd_out = 32'd0; wdata_seen = 32'd0; wstrb_seen = 4'd0; berr_seen = 1'b0;
        for (int k = 0; k <= done_k + 1; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                MemRead_M = rd; MemWrite_M = wr; funct3_M = f3;
                ALUResult_M = addr; WriteData_M = wd; dmem_rdata = rdata;
            end
            if (k == done_k + 1) begin
                MemRead_M = 1'b0; MemWrite_M = 1'b0;
            end
            dmem_req_ready  = acc && (k == 1 + dr);
            // Responses in REQ and after a timeout must be ignored.
            dmem_resp_valid = (acc && k >= 1 && k <= dr) ||
                              (rd && acc && !no_resp && k == 2 + dr + ds) ||
                              (tmo && k == done_k + 1);
            @(negedge clk);
            if (Stall_M) stall_cnt++;
            if (k <= done_k) chk({name, " misaligned"}, 32'(misaligned_M), 32'(mis));
            chk({name, " stall"}, 32'(Stall_M), 32'(k < done_k));
            chk({name, " req_valid"}, 32'(dmem_req_valid), 32'(acc && k >= 1 && k <= 1 + dr));
            chk({name, " bus_error"}, 32'(bus_error_M), 32'(tmo && k == done_k));
            if (bus_error_M) berr_seen = 1'b1;
            if (acc && k >= 1 && k <= 1 + dr) begin
                chk({name, " addr"}, dmem_addr, {addr[31:2], 2'b00});
                chk({name, " we"}, 32'(dmem_we), 32'(wr));
                if (wr) begin
                    chk({name, " wdata"}, dmem_wdata, m_wdata(f3, wd));
                    chk({name, " wstrb"}, 32'(dmem_wstrb), 32'(m_wstrb(f3, addr)));
                end
                if (k == 1) begin
                    wdata_seen = dmem_wdata; wstrb_seen = dmem_wstrb;
                end
            end
            if (rd && acc && k == done_k) chk({name, " rdata_done"}, ReadData_M, exp_rd);
            if (rd && k == done_k + 1) begin
                chk({name, " rdata_after"}, ReadData_M, exp_rd);
                rd_out = ReadData_M;
            end
        end
        dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0;
        $display("txn %-8s rd=%0b wr=%0b f3=%03b addr=0x%08h stall=%0d rdata=0x%08h berr=%0b",
                 name, rd, wr, f3, addr, stall_cnt, rd_out, berr_seen);
    endtask

    int          sc;
    logic [31:0] ro, ws;
    logic [3:0]  st;
    logic        be;

    initial begin
        rst = 1'b1; MemRead_M = 0; MemWrite_M = 0; funct3_M = 3'b000;
        ALUResult_M = 0; WriteData_M = 0; dmem_req_ready = 0; dmem_resp_valid = 0;
        dmem_rdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset stall", 32'(Stall_M), 32'd0);
        chk("reset req_valid", 32'(dmem_req_valid), 32'd0);
        chk("reset rdata", ReadData_M, 32'd0);
        chk("reset bus_error", 32'(bus_error_M), 32'd0);
        chk("reset wstrb", 32'(dmem_wstrb), 32'd0);
        chk("reset addr", dmem_addr, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        run_txn("SW", 0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0, sc, ro, ws, st, be);
        chk("SW stall literal", 32'(sc), 32'd2);
        chk("SW wdata literal", ws, 32'hDEADBEEF);
        run_txn("SB", 0, 1, 3'b000, 32'h103, 32'h000000A5, 0, 1, 0, 0, sc, ro, ws, st, be);
        chk("SB wdata literal", ws, 32'hA5A5A5A5);
        chk("SB wstrb literal", 32'(st), 32'h8);
        run_txn("SH", 0, 1, 3'b001, 32'h102, 32'h1234BEEF, 0, 0, 0, 0, sc, ro, ws, st, be);
        chk("SH wstrb literal", 32'(st), 32'hC);
        run_txn("LB", 1, 0, 3'b000, 32'h102, 0, 32'h1280FF00, 0, 0, 0, sc, ro, ws, st, be);
        chk("LB literal", ro, 32'hFFFFFF80);
        chk("LB stall literal", 32'(sc), 32'd3);
        run_txn("LBU", 1, 0, 3'b100, 32'h102, 0, 32'h1280FF00, 0, 0, 0, sc, ro, ws, st, be);
        chk("LBU literal", ro, 32'h00000080);
        run_txn("LH_mis", 1, 0, 3'b001, 32'h101, 0, 32'h1280FF00, 0, 0, 0, sc, ro, ws, st, be);
        chk("LH_mis rdata literal", ro, 32'd0);
        chk("LH_mis stall literal", 32'(sc), 32'd0);
        run_txn("SW_mis", 0, 1, 3'b010, 32'h102, 32'h11223344, 0, 0, 0, 0, sc, ro, ws, st, be);
        run_txn("LH", 1, 0, 3'b001, 32'h102, 0, 32'h80017FFF, 0, 0, 0, sc, ro, ws, st, be);
        chk("LH literal", ro, 32'hFFFF8001);
        run_txn("LHU", 1, 0, 3'b101, 32'h100, 0, 32'h80018FFF, 0, 1, 0, sc, ro, ws, st, be);
        chk("LHU literal", ro, 32'h00008FFF);
        run_txn("LW_slow", 1, 0, 3'b010, 32'h104, 0, 32'hCAFEF00D, 3, 4, 0, sc, ro, ws, st, be);
        chk("LW_slow stall literal", 32'(sc), 32'd10);
        chk("LW_slow literal", ro, 32'hCAFEF00D);

        // Reset while waiting for a load response, then a late response.
        @(posedge clk); #1;
        MemRead_M = 1; funct3_M = 3'b010; ALUResult_M = 32'h200; dmem_rdata = 32'h12345678;
        @(posedge clk); #1 dmem_req_ready = 1;
        @(negedge clk); chk("rstw req_valid", 32'(dmem_req_valid), 32'd1);
        @(posedge clk); #1 dmem_req_ready = 0;
        @(negedge clk); chk("rstw stall in WAIT", 32'(Stall_M), 32'd1);
        @(posedge clk); #1 rst = 1; MemRead_M = 0;
        @(negedge clk);
        chk("rstw req_valid", 32'(dmem_req_valid), 32'd0);
        chk("rstw stall", 32'(Stall_M), 32'd0);
        chk("rstw rdata cleared", ReadData_M, 32'd0);
        @(posedge clk); #1 rst = 0; dmem_resp_valid = 1;
        repeat (2) begin
            @(negedge clk);
            chk("late resp rdata", ReadData_M, 32'd0);
            chk("late resp stall", 32'(Stall_M), 32'd0);
            chk("late resp req_valid", 32'(dmem_req_valid), 32'd0);
            chk("late resp bus_error", 32'(bus_error_M), 32'd0);
        end
        @(posedge clk); #1 dmem_resp_valid = 0;
        $display("txn rst_wait abandoned LW at 0x00000200");

        run_txn("LW", 1, 0, 3'b010, 32'h10C, 0, 32'h0BADF00D, 0, 0, 0, sc, ro, ws, st, be);
        run_txn("LW_tmo", 1, 0, 3'b010, 32'h108, 0, 32'h55555555, 0, 0, 1, sc, ro, ws, st, be);
        chk("LW_tmo bus_error literal", 32'(be), 32'd1);
        chk("LW_tmo stall literal", 32'(sc), 32'(2 + T));
        run_txn("S_f3_011", 0, 1, 3'b011, 32'h110, 32'h01020304, 0, 0, 0, 0, sc, ro, ws, st, be);
        chk("f3 011 wstrb literal", 32'(st), 32'hF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
